uart_rx_frame: RTL

- Serial UART receiver; the stage directly upstream of the system controller's command decoder.
- Oversamples RX_IN at Prescale x baud, deframes start/8 data/optional parity/stop.
- Delivers P_DATA with a one-cycle data_valid pulse; the controller consumes these as UART_RX_P_Data / UART_RX_D_VLD after the RX-to-REF data synchroniser.
- Flags parity and stop errors; errored frames are dropped.

---
 rtl/uart_rx_pkg.sv | 24 ++
 rtl/uart_rx_sampler.sv | 54 +++++
 rtl/uart_rx_frame.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// legal oversampling ratios, parity type codes and the 2-of-3 vote helper.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit sampler for the UART receiver. Reports the bit value of the current
// bit period and a one-cycle sample_done strobe when that value is final.
// Build option UART_RX_MAJORITY_VOTE_EN: vote over three samples around the
// mid-bit point, resolved one cycle after the centre; otherwise a single
// sample taken at the centre (edge_cnt == prescale/2).
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6
) (
`ifdef UART_RX_MAJORITY_VOTE_EN
    input  logic                      clk,
    input  logic                      rst_n,
`endif
    input  logic                      rx_in,
    input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      sampled_bit,
    output logic                      sample_done
);

    logic [PRESCALE_WIDTH-1:0] half;
    assign half = prescale >> 1;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic s0_q, s0_d, s1_q, s1_d;

    // Capture the samples just before and at the centre; the third is live.
    always_comb begin
        s0_d = s0_q;
        s1_d = s1_q;
        if (edge_cnt == half - 1'b1) s0_d = rx_in;
        if (edge_cnt == half)        s1_d = rx_in;
    end

    // Sample holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q <= 1'b1;
            s1_q <= 1'b1;
        end else begin
            s0_q <= s0_d;
            s1_q <= s1_d;
        end
    end

    assign sample_done = (edge_cnt == half + 1'b1);
    assign sampled_bit = majority3(s0_q, s1_q, rx_in);
`else
    assign sample_done = (edge_cnt == half);
    assign sampled_bit = rx_in;
`endif

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start / DATA_WIDTH data bits (LSB first) / optional
// parity / stop, oversampled at Prescale x baud. Good frames update P_DATA
// with a one-cycle data_valid; bad frames pulse par_err / stp_err and are
// dropped. Build option UART_RX_MAJORITY_VOTE_EN selects 2-of-3 voting in
// the sampler; frame timing is the same either way.
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_e                 state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic                      par_fail_q, par_fail_d;
    logic                      stp_fail_q, stp_fail_d;
    logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
    logic                      data_valid_q, data_valid_d;
    logic                      par_err_q, par_err_d;
    logic                      stp_err_q, stp_err_d;

    logic sampled_bit, sample_done, last_edge;

    // Final cycle of the current bit period, using the ratio latched at start.
    assign last_edge = (edge_cnt_q == prescale_q - 1'b1);

    uart_rx_sampler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_sampler (
`ifdef UART_RX_MAJORITY_VOTE_EN
        .clk         (CLK),
        .rst_n       (RST),
`endif
        .rx_in       (RX_IN),
        .edge_cnt    (edge_cnt_q),
        .prescale    (prescale_q),
        .sampled_bit (sampled_bit),
        .sample_done (sample_done)
    );

    // Frame FSM, counters, deserializer and error checks.
    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = last_edge ? '0 : edge_cnt_q + 1'b1;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_fail_d   = par_fail_q;
        stp_fail_d   = stp_fail_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!RX_IN) begin
                    // This cycle is edge 0 of the start bit.
                    state_d    = ST_START;
                    edge_cnt_d = PRESCALE_WIDTH'(1);
                    prescale_d = Prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_fail_d = 1'b0;
                    stp_fail_d = 1'b0;
                end
            end
            ST_START: begin
                if (sample_done && sampled_bit) begin
                    state_d    = ST_IDLE;
                    edge_cnt_d = '0;
                end else if (last_edge) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (sample_done) shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                if (last_edge) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                // Expected bit is the data XOR, inverted for odd parity.
                if (sample_done)
                    par_fail_d = sampled_bit ^ (^shift_q) ^ (par_typ_q == PAR_ODD);
                if (last_edge) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (sample_done && !sampled_bit) stp_fail_d = 1'b1;
                if (last_edge) begin
                    state_d    = ST_IDLE;
                    edge_cnt_d = '0;
                    if (!par_fail_q && !stp_fail_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end else begin
                        par_err_d = par_fail_q;
                        stp_err_d = stp_fail_q;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            prescale_q   <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_fail_q   <= 1'b0;
            stp_fail_q   <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_fail_q   <= par_fail_d;
            stp_fail_q   <= stp_fail_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule
